// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM states
// and a small op-class helper.
package usr_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL   = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR   = 3'b011;
    localparam logic [OP_W-1:0] OP_SAR   = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL   = 3'b101;
    localparam logic [OP_W-1:0] OP_ROR   = 3'b110;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } usr_state_e;

    // True for the ops that step the register one bit per clock.
    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the universal shift register.
// Ports:
//   op      - operation code (shift/rotate ops act, all others pass q through)
//   q       - current register value
//   sin_l   - fill bit entering at the MSB on SHR
//   sin_r   - fill bit entering at the LSB on SHL
//   next_q  - register value after one step
//   out_bit - bit leaving the register on this step (0 for non-shift ops)
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] q,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], sin_r};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {sin_l, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_SAR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register with a valid/ready command port.
// Shift and rotate commands advance one bit per clock for cmd_amt clocks;
// LOAD, CLEAR, NOP and zero-amount shifts complete in a single cycle.
// Optional feature macro: USR_CARRY_EN adds the carry output and its flop.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake (accepted when both high)
//   cmd_op/amt/data       - op code, shift amount, parallel load value
//   sin_l, sin_r          - serial fill bits for SHR / SHL
//   q                     - register contents
//   busy, done            - executing status, one-cycle completion pulse
//   carry                 - last bit shifted/rotated out (USR_CARRY_EN only)
module param_universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef USR_CARRY_EN
    ,
    output logic             carry
`endif
);

    usr_state_e       state_q;
    usr_state_e       state_d;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] cnt_d;
    logic [OP_W-1:0]  op_q;
    logic [OP_W-1:0]  op_d;
    logic [WIDTH-1:0] q_d;
    logic             ready_d;
    logic             done_d;
    logic             accept_c;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign accept_c = cmd_valid && (state_q == ST_IDLE);

    // Single-bit step datapath, driven by the latched op.
    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_q),
        .q       (q),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .next_q  (step_q),
        .out_bit (step_out)
    );

    // State, datapath and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            q         <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            q         <= q_d;
            cmd_ready <= ready_d;
            busy      <= !ready_d;
            done      <= done_d;
        end
    end

    // Next-state logic: multi-cycle only for shift ops with a nonzero amount.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (is_shift_op(cmd_op) && (cmd_amt != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they leave a flop.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Datapath next values: latch the command on accept, step while shifting.
    always_comb begin
        q_d   = q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (accept_c) begin
            op_d  = cmd_op;
            cnt_d = is_shift_op(cmd_op) ? cmd_amt : '0;
            case (cmd_op)
                OP_LOAD:  q_d = cmd_data;
                OP_CLEAR: q_d = '0;
                default:  q_d = q;
            endcase
        end else if (state_q == ST_SHIFT) begin
            q_d   = step_q;
            cnt_d = cnt_q - AMT_W'(1);
        end
    end

`ifdef USR_CARRY_EN
    // Carry tracks the bit leaving on each step; LOAD/CLEAR zero it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry <= 1'b0;
        end else if (accept_c && ((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR))) begin
            carry <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            carry <= step_out;
        end
    end
`else
    logic unused_step_out;
    assign unused_step_out = step_out;
`endif

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Self-checking bench for param_universal_shift_register (WIDTH=8):
// directed vector table, hand-written handshake/reset sequences, and random
// commands checked against an arithmetic reference model.
module tb_param_universal_shift_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;

    localparam logic [2:0] T_NOP   = 3'b000;
    localparam logic [2:0] T_LOAD  = 3'b001;
    localparam logic [2:0] T_SHL   = 3'b010;
    localparam logic [2:0] T_SHR   = 3'b011;
    localparam logic [2:0] T_SAR   = 3'b100;
    localparam logic [2:0] T_ROL   = 3'b101;
    localparam logic [2:0] T_ROR   = 3'b110;
    localparam logic [2:0] T_CLEAR = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
`ifdef USR_CARRY_EN
    logic             carry;
`endif

    always #5 clk = ~clk;

    param_universal_shift_register #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .busy      (busy),
        .done      (done)
`ifdef USR_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] mq;
    logic       mc;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] pre;
        logic [7:0] data;
        logic       sl;
        logic       sr;
        logic [7:0] exp_q;
        logic       exp_c;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-command reference: result of n steps computed in one expression.
    task automatic model_apply(input logic [2:0] op, input logic [2:0] n,
                               input logic [7:0] d, input logic sl, input logic sr);
        int v;
        int k;
        v = int'(mq);
        k = int'(n);
        case (op)
            T_LOAD:  begin mq = d;     mc = 1'b0; end
            T_CLEAR: begin mq = 8'h00; mc = 1'b0; end
            T_NOP:   ;
            default: if (k != 0) begin
                case (op)
                    T_SHL: begin
                        mc = mq[8-k];
                        mq = 8'(((v << k) | (sr ? ((1 << k) - 1) : 0)) & 255);
                    end
                    T_SHR: begin
                        mc = mq[k-1];
                        mq = 8'((v >> k) | (sl ? ((255 << (8 - k)) & 255) : 0));
                    end
                    T_SAR: begin
                        mc = mq[k-1];
                        mq = 8'($signed(mq) >>> k);
                    end
                    T_ROL: begin
                        mc = mq[8-k];
                        mq = 8'(((v << k) | (v >> (8 - k))) & 255);
                    end
                    default: begin
                        mc = mq[k-1];
                        mq = 8'(((v >> k) | (v << (8 - k))) & 255);
                    end
                endcase
            end
        endcase
    endtask

    // Issue one command, wait for done, and check result, latency and busy.
    task automatic check_cmd(input string tag, input logic [2:0] op, input logic [2:0] amt,
                             input logic [7:0] d, input logic sl, input logic sr);
        int waitc;
        int lat;
        int busyc;
        int exp_lat;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!cmd_ready) chk({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = d;
        sin_l     = sl;
        sin_r     = sr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_amt   = 3'($urandom);
        cmd_data  = 8'($urandom);
        lat   = 1;
        busyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busyc++;
        end
        model_apply(op, amt, d, sl, sr);
        exp_lat = ((op >= T_SHL) && (op <= T_ROR) && (amt != 3'd0)) ? int'(amt) + 1 : 1;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busyc), 32'(exp_lat));
        chk({tag, "_q"}, 32'(q), 32'(mq));
`ifdef USR_CARRY_EN
        chk({tag, "_carry"}, 32'(carry), 32'(mc));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int lowc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        cmd_amt   = '0;
        cmd_data  = '0;
        sin_l     = 1'b0;
        sin_r     = 1'b0;
        mq        = 8'h00;
        mc        = 1'b0;

        // Reset and hold.
        #1 rst = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef USR_CARRY_EN
        chk("rst_carry", 32'(carry), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_q", 32'(q), 32'h00);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_cmd("load_aa", T_LOAD, 3'd0, 8'hAA, 1'b0, 1'b0);
        chk("load_aa_const", 32'(q), 32'hAA);

        // Directed vector table.
        vt[0]  = '{T_SHR,   3'd3, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h15, 1'b0};
        vt[1]  = '{T_SHL,   3'd3, 8'hAA, 8'h00, 1'b0, 1'b1, 8'h57, 1'b1};
        vt[2]  = '{T_SAR,   3'd7, 8'h80, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
        vt[3]  = '{T_ROL,   3'd1, 8'h81, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1};
        vt[4]  = '{T_ROR,   3'd1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1};
        vt[5]  = '{T_ROR,   3'd0, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0};
        vt[6]  = '{T_CLEAR, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[7]  = '{T_NOP,   3'd0, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0};
        vt[8]  = '{T_LOAD,  3'd0, 8'h00, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0};
        vt[9]  = '{T_SHR,   3'd7, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1};
        vt[10] = '{T_SHL,   3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0};
        for (int i = 0; i < 11; i++) begin
            check_cmd($sformatf("vec%0d_pre", i), T_LOAD, 3'd0, vt[i].pre, 1'b0, 1'b0);
            check_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].amt, vt[i].data, vt[i].sl, vt[i].sr);
            chk($sformatf("vec%0d_table_q", i), 32'(q), 32'(vt[i].exp_q));
`ifdef USR_CARRY_EN
            chk($sformatf("vec%0d_table_c", i), 32'(carry), 32'(vt[i].exp_c));
`endif
        end

        // CLEAR after a carry-producing rotate; amt=0 after that keeps state.
        check_cmd("cl_pre", T_LOAD, 3'd0, 8'h81, 1'b0, 1'b0);
        check_cmd("cl_rol", T_ROL, 3'd1, 8'h00, 1'b0, 1'b0);
        check_cmd("cl_rol0", T_ROL, 3'd0, 8'h00, 1'b0, 1'b0);
        chk("cl_rol0_q", 32'(q), 32'h03);
        check_cmd("cl_clear", T_CLEAR, 3'd0, 8'hFF, 1'b0, 1'b0);
        chk("cl_clear_q", 32'(q), 32'h00);

        // Handshake: LOAD held during SHL amt=5 is accepted only once idle.
        check_cmd("hs_pre", T_LOAD, 3'd0, 8'h0F, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = T_SHL;
        cmd_amt   = 3'd5;
        sin_r     = 1'b0;
        @(posedge clk); #1;
        cmd_op   = T_LOAD;
        cmd_data = 8'h55;
        lowc = 0;
        while (!cmd_ready && lowc < 20) begin
            chk("hs_q_not_loaded", 32'(q == 8'h55), 32'd0);
            lowc++;
            @(posedge clk); #1;
        end
        chk("hs_busy_cycles", 32'(lowc), 32'd6);
        chk("hs_shifted_q", 32'(q), 32'hE0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("hs_load_done", 32'(done), 32'd1);
        chk("hs_load_q", 32'(q), 32'h55);
        mq = 8'h55;
        mc = 1'b0;
        @(posedge clk); #1;
        chk("hs_ready_back", 32'(cmd_ready), 32'd1);

        // Reset mid-operation: ROR amt=7 from 0xF0, reset after 3rd step.
        check_cmd("mr_pre", T_LOAD, 3'd0, 8'hF0, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = T_ROR;
        cmd_amt   = 3'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_q_step3", 32'(q), 32'h1E);
        rst = 1'b0;
        #1;
        chk("mr_q", 32'(q), 32'h00);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        chk("mr_done", 32'(done), 32'd0);
`ifdef USR_CARRY_EN
        chk("mr_carry", 32'(carry), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mr_no_done", 32'(done), 32'd0);
        end
        chk("mr_ready_after", 32'(cmd_ready), 32'd1);
        chk("mr_q_after", 32'(q), 32'h00);
        mq = 8'h00;
        mc = 1'b0;

        // Random commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            check_cmd($sformatf("rnd%0d", i), 3'($urandom), 3'($urandom_range(0, 7)),
                      8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
